// File: rtl/day10_subset_search.sv
// Day 10 part 1 solver: loads a target plus button masks, tries every button subset
// once per cycle and reports the smallest matching one. DAY10_GRAY_ENUM_EN selects Gray-order walking.
module day10_subset_search #(
  parameter int MAX_NUM_LIGHTS    = 10,
  parameter int MAX_NUM_BUTTONS   = 13,
  parameter int MAX_NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 1),
  parameter int MAX_NUM_PRESSES_W = MAX_NUM_BUTTONS_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [MAX_NUM_LIGHTS-1:0]    cfg_target,
  input  logic [MAX_NUM_BUTTONS_W-1:0] cfg_num_buttons,
  input  logic                         btn_valid,
  output logic                         btn_ready,
  input  logic [MAX_NUM_LIGHTS-1:0]    btn_mask,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_found,
  output logic [MAX_NUM_PRESSES_W-1:0] min_button_presses,
  output logic [MAX_NUM_BUTTONS-1:0]   buttons_to_press
);
  // state  | meaning
  // IDLE   | waiting for target and button count
  // LOAD   | accepting button masks into slots 0..N-1
  // SEARCH | one subset evaluated per cycle, 2^N cycles
  // DONE   | result registered, then held until consumed
  localparam int LW = MAX_NUM_LIGHTS;
  localparam int NB = MAX_NUM_BUTTONS;
  localparam int BW = MAX_NUM_BUTTONS_W;
  localparam int PW = MAX_NUM_PRESSES_W;
  localparam int SW = MAX_NUM_BUTTONS + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEARCH, S_DONE} state_e;
  state_e state_q, state_d;

  logic [LW-1:0] target_q;
  logic [BW-1:0] n_q, k_q, n_clamped;
  logic [LW-1:0] masks_q [NB];
  logic [SW-1:0] s_q, last_s;
  logic          best_found_q;
  logic [PW-1:0] best_pc_q;
  logic [NB-1:0] best_sub_q;
  logic          res_valid_q, res_found_q;
  logic [PW-1:0] res_min_q;
  logic [NB-1:0] res_sub_q;
  logic [NB-1:0] cand_sub;
  logic [LW-1:0] cand_acc;
  logic [PW-1:0] cand_pc;
  logic          cfg_ready_c, btn_ready_c, cand_better;

  assign n_clamped = (cfg_num_buttons > BW'(NB)) ? BW'(NB) : cfg_num_buttons;
  assign last_s    = (SW'(1) << n_q) - SW'(1);

`ifdef DAY10_GRAY_ENUM_EN
  // Gray walk: exactly one button changes per step, so acc/pc are updated incrementally.
  logic [NB-1:0] gray_q;
  logic [LW-1:0] acc_q;
  logic [PW-1:0] pc_q;
  logic [SW-1:0] s_inc;
  logic [BW-1:0] flip_idx;

  always_comb begin
    s_inc    = s_q + SW'(1);
    flip_idx = '0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (s_inc[b]) flip_idx = BW'(b);
    end
  end

  assign cand_sub = gray_q;
  assign cand_acc = acc_q;
  assign cand_pc  = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
      acc_q  <= '0;
      pc_q   <= '0;
    end else if (state_q == S_SEARCH) begin
      gray_q[flip_idx] <= ~gray_q[flip_idx];
      acc_q            <= acc_q ^ masks_q[flip_idx];
      pc_q             <= gray_q[flip_idx] ? pc_q - PW'(1) : pc_q + PW'(1);
    end else begin
      gray_q <= '0;
      acc_q  <= '0;
      pc_q   <= '0;
    end
  end
`else
  always_comb begin
    cand_sub = s_q[NB-1:0];
    cand_acc = '0;
    cand_pc  = '0;
    for (int b = 0; b < NB; b++) begin
      if (s_q[b]) begin
        cand_acc = cand_acc ^ masks_q[b];
        cand_pc  = cand_pc + PW'(1);
      end
    end
  end
`endif

  assign cand_better = (cand_acc == target_q) && (cand_pc < best_pc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cfg_ready_c = 1'b0;
    btn_ready_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        cfg_ready_c = 1'b1;
        if (cfg_valid) state_d = (n_clamped == '0) ? S_SEARCH : S_LOAD;
      end
      S_LOAD: begin
        btn_ready_c = 1'b1;
        if (btn_valid && (k_q == n_q - BW'(1))) state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (s_q == last_s) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_valid_q && res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // cfg_ready is gated by rst_n so every output reads 0 while reset is held.
  assign cfg_ready          = cfg_ready_c & rst_n;
  assign btn_ready          = btn_ready_c;
  assign res_valid          = res_valid_q;
  assign res_found          = res_found_q;
  assign min_button_presses = res_min_q;
  assign buttons_to_press   = res_sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q     <= '0;
      n_q          <= '0;
      k_q          <= '0;
      s_q          <= '0;
      best_found_q <= 1'b0;
      best_pc_q    <= '1;
      best_sub_q   <= '0;
      res_valid_q  <= 1'b0;
      res_found_q  <= 1'b0;
      res_min_q    <= '0;
      res_sub_q    <= '0;
      for (int i = 0; i < NB; i++) masks_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          s_q          <= '0;
          best_found_q <= 1'b0;
          best_pc_q    <= '1;
          best_sub_q   <= '0;
          if (state_q == S_IDLE && cfg_valid) begin
            target_q <= cfg_target;
            n_q      <= n_clamped;
            k_q      <= '0;
            for (int i = 0; i < NB; i++) masks_q[i] <= '0;
          end
          if (state_q == S_LOAD && btn_valid) begin
            masks_q[k_q] <= btn_mask;
            k_q          <= k_q + BW'(1);
          end
        end
        S_SEARCH: begin
          s_q <= s_q + SW'(1);
          if (cand_better) begin
            best_found_q <= 1'b1;
            best_pc_q    <= cand_pc;
            best_sub_q   <= cand_sub;
          end
        end
        S_DONE: begin
          // First DONE cycle commits the best subset; fields then hold until the next job.
          if (!res_valid_q) begin
            res_valid_q <= 1'b1;
            res_found_q <= best_found_q;
            res_min_q   <= best_pc_q;
            res_sub_q   <= best_sub_q;
          end else if (res_ready) begin
            res_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_day10_subset_search.sv
// Bench for day10_subset_search: directed and random jobs checked against a brute-force model.
module tb_day10_subset_search;
  localparam int NL = 10;
  localparam int NB = 13;
  localparam int BW = 4;
  localparam int PW = 4;
`ifdef DAY10_GRAY_ENUM_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0, cfg_ready;
  logic [NL-1:0] cfg_target = '0;
  logic [BW-1:0] cfg_num_buttons = '0;
  logic          btn_valid = 1'b0, btn_ready;
  logic [NL-1:0] btn_mask = '0;
  logic          res_valid, res_ready = 1'b0, res_found;
  logic [PW-1:0] min_button_presses;
  logic [NB-1:0] buttons_to_press;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  logic [NL-1:0] job_masks [20];

  day10_subset_search dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_target(cfg_target),
    .cfg_num_buttons(cfg_num_buttons),
    .btn_valid(btn_valid), .btn_ready(btn_ready), .btn_mask(btn_mask),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
    .min_button_presses(min_button_presses), .buttons_to_press(buttons_to_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Brute force in the enumeration order of the build; first minimum wins.
  function automatic void model(input logic [NL-1:0] tgt, input int n, output logic f,
                                output logic [PW-1:0] mn, output logic [NB-1:0] sb);
    int best;
    best = 15; f = 1'b0; sb = '0;
    for (int i = 0; i < (1 << n); i++) begin
      int sub;
      int pc;
      logic [NL-1:0] acc;
      sub = GRAY ? (i ^ (i >> 1)) : i;
      acc = '0; pc = 0;
      for (int b = 0; b < n; b++) if (((sub >> b) & 1) == 1) begin acc ^= job_masks[b]; pc++; end
      if (acc == tgt && pc < best) begin best = pc; sb = NB'(sub); f = 1'b1; end
    end
    mn = PW'(best);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 0);
    chk({tag, "_btn_ready"}, 32'(btn_ready), 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_found"}, 32'(res_found), 0);
    chk({tag, "_min"}, 32'(min_button_presses), 0);
    chk({tag, "_sub"}, 32'(buttons_to_press), 0);
  endtask

  task automatic send_cfg(input logic [NL-1:0] tgt, input int nreq, output bit ok, output int hs);
    int w;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_target = tgt; cfg_num_buttons = BW'(nreq > 15 ? 15 : nreq);
    w = 0;
    while (!cfg_ready && w < 50) begin @(negedge clk); w++; end
    ok = cfg_ready;
    if (ok) begin @(posedge clk); #1; end
    cfg_valid = 1'b0;
    hs = cyc_cnt;
  endtask

  task automatic run_job(input string tag, input logic [NL-1:0] tgt, input int nreq, input int hold);
    bit ok;
    int hs, w, acc_cnt, n_eff, offer, pc;
    logic f;
    logic [PW-1:0] mn;
    logic [NB-1:0] sb;
    logic [NL-1:0] x;
    offer = nreq > 15 ? 15 : nreq;
    n_eff = offer > NB ? NB : offer;
    send_cfg(tgt, nreq, ok, hs);
    chk({tag, "_cfg_accept"}, 32'(ok), 1);
    if (!ok) return;
    acc_cnt = 0;
    for (int i = 0; i < offer; i++) begin
      @(negedge clk);
      btn_valid = 1'b1; btn_mask = job_masks[i];
      if (!btn_ready) begin btn_valid = 1'b0; break; end
      @(posedge clk); #1;
      btn_valid = 1'b0; acc_cnt++; hs = cyc_cnt;
    end
    chk({tag, "_btn_accepts"}, 32'(acc_cnt), 32'(n_eff));
    @(negedge clk);
    w = 0;
    while (!res_valid && w < 20000) begin @(negedge clk); w++; end
    chk({tag, "_res_valid"}, 32'(res_valid), 1);
    chk({tag, "_latency"}, 32'(cyc_cnt - hs), 32'((1 << n_eff) + 1));
    model(tgt, n_eff, f, mn, sb);
    chk({tag, "_found"}, 32'(res_found), 32'(f));
    chk({tag, "_min"}, 32'(min_button_presses), 32'(mn));
    chk({tag, "_sub"}, 32'(buttons_to_press), 32'(sb));
    if (f) begin
      x = '0; pc = 0;
      for (int b = 0; b < NB; b++) if (buttons_to_press[b]) begin
        pc++;
        if (b < n_eff) x ^= job_masks[b];
      end
      chk({tag, "_sub_xor"}, 32'(x), 32'(tgt));
      chk({tag, "_sub_pc"}, 32'(pc), 32'(mn));
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(res_valid), 1);
      chk({tag, "_hold_cfg_ready"}, 32'(cfg_ready), 0);
      chk({tag, "_hold_fields"}, {res_found, min_button_presses, buttons_to_press}, {f, mn, sb});
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_cfg_ready"}, 32'(cfg_ready), 1);
    chk({tag, "_post_valid"}, 32'(res_valid), 0);
    chk({tag, "_post_fields"}, {res_found, min_button_presses, buttons_to_press}, {f, mn, sb});
  endtask

  task automatic partial_job(input int ncfg, input int nbtn);
    bit ok;
    int hs;
    for (int i = 0; i < 20; i++) job_masks[i] = NL'($urandom);
    send_cfg(NL'($urandom), ncfg, ok, hs);
    for (int i = 0; i < nbtn; i++) begin
      @(negedge clk);
      btn_valid = 1'b1; btn_mask = job_masks[i];
      @(posedge clk); #1;
      btn_valid = 1'b0;
    end
  endtask

  initial begin
    logic [NL-1:0] t;
    int n;
    repeat (3) @(negedge clk);
    chk_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    chk("rst_btn_ready", 32'(btn_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_fields", {res_found, min_button_presses, buttons_to_press}, 0);

    job_masks[0] = 10'h8; job_masks[1] = 10'hA; job_masks[2] = 10'h4;
    job_masks[3] = 10'hC; job_masks[4] = 10'h5; job_masks[5] = 10'h3;
    run_job("t1", 10'h6, 6, 10);
    chk("t1_sub_const", 32'(buttons_to_press), 32'h00A);
    chk("t1_min_const", 32'(min_button_presses), 2);

    job_masks[0] = 10'h1D; job_masks[1] = 10'h0C; job_masks[2] = 10'h11;
    job_masks[3] = 10'h07; job_masks[4] = 10'h1E;
    run_job("t2", 10'h08, 5, 0);
    chk("t2_min_const", 32'(min_button_presses), 3);

    job_masks[0] = 10'h1; job_masks[1] = 10'h1;
    run_job("t3", 10'h3, 2, 0);
    chk("t3_none", {res_found, min_button_presses, buttons_to_press}, {1'b0, 4'hF, 13'h0});

    run_job("t4_n0", 10'h0, 0, 0);
    chk("t4_n0_min_const", 32'(min_button_presses), 0);

    for (int i = 0; i < 20; i++) job_masks[i] = NL'($urandom);
    run_job("t5_clamp", job_masks[2] ^ job_masks[7] ^ job_masks[11], 20, 0);

    for (int j = 0; j < 8; j++) begin
      n = int'($urandom_range(1, 9));
      for (int i = 0; i < 20; i++) job_masks[i] = NL'($urandom_range(0, 63));
      t = ($urandom_range(0, 1) == 1) ? NL'($urandom_range(0, 63))
                                      : job_masks[0] ^ job_masks[n - 1];
      run_job("rand", t, n, j % 3);
    end

    partial_job(6, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_load");
    @(negedge clk);
    rst_n = 1'b1;
    job_masks[0] = 10'h30; job_masks[1] = 10'h0F; job_masks[2] = 10'h3F;
    run_job("after_rst_load", 10'h0F, 3, 0);

    partial_job(10, 10);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_search");
    @(negedge clk);
    rst_n = 1'b1;
    job_masks[0] = 10'h201; job_masks[1] = 10'h102; job_masks[2] = 10'h303; job_masks[3] = 10'h004;
    run_job("after_rst_search", 10'h307, 4, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/day10_subset_search.md
Name: day10_subset_search

Overview:
- Per-machine solver for Day 10 part 1: minimum number of button presses that turns the all-off light vector into the target vector. Each press XOR-toggles that button's light mask.
- Accepts one target pattern plus up to MAX_NUM_BUTTONS button masks over two valid/ready channels. Then enumerates every button subset, one per cycle.
- Tracks the lowest-popcount matching subset and presents it on a result channel. The result fields drive the producer side of day10_output_if.

Parameters:
- MAX_NUM_LIGHTS, 10, light-vector width; bit i = light i.
- MAX_NUM_BUTTONS, 13, button-mask storage depth and subset-vector width.
- MAX_NUM_BUTTONS_W, $clog2(MAX_NUM_BUTTONS+1), width of button counts.
- MAX_NUM_PRESSES_W, MAX_NUM_BUTTONS_W, width of min_button_presses.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  target/count offer.
- cfg_ready  out  1  high only in IDLE.
- cfg_target  in  MAX_NUM_LIGHTS  required light pattern.
- cfg_num_buttons  in  MAX_NUM_BUTTONS_W  buttons that follow; values above MAX_NUM_BUTTONS clamp to MAX_NUM_BUTTONS.
- btn_valid  in  1  button mask offer.
- btn_ready  out  1  high only in LOAD.
- btn_mask  in  MAX_NUM_LIGHTS  lights toggled by the next button, in index order.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_found  out  1  some subset reaches cfg_target.
- min_button_presses  out  MAX_NUM_PRESSES_W  popcount of the best subset.
- buttons_to_press  out  MAX_NUM_BUTTONS  best subset; bit b = press button b.

Behaviour:
- Reset (async assert, sync deassert): state IDLE, all outputs 0, cfg_ready=1 from the first post-reset cycle.
- A reset in any state aborts the operation and discards stored masks. Partial results are never presented.
- IDLE:
  - On cfg_valid&cfg_ready, latch target and the clamped count N.
  - N=0 goes to SEARCH directly; otherwise go to LOAD.
- LOAD:
  - Each btn_valid&btn_ready writes btn_mask into slot k, k=0..N-1.
  - After slot N-1, go to SEARCH.
  - Unused slots read as 0.
- SEARCH:
  - Subset counter s, MAX_NUM_BUTTONS+1 bits wide, starts at 0 and advances one per cycle.
  - Each cycle evaluates subset(s): acc = XOR of masks for set bits, pc = popcount.
  - Match means acc==target.
  - Best is updated only when a match has pc strictly less than best_pc. best_pc initialises to all-ones and best_subset to 0. Ties keep the first subset encountered.
  - Exactly 2^N subsets are evaluated, so SEARCH lasts 2^N cycles. Then go to DONE.
  - The empty subset is evaluated first. target==0 therefore yields found=1, presses=0, subset=0.
- DONE:
  - res_valid=1, with fields registered and stable while res_valid&!res_ready.
  - When nothing matched: res_found=0, min_button_presses=all-ones, buttons_to_press=0.
  - res_valid&res_ready returns to IDLE. Outputs hold their last values until the next DONE; only res_valid drops.
  - cfg_ready=0 in every state except IDLE. btn_ready=0 outside LOAD. Offers in other states are ignored.
- Latency: from the last accepted button handshake to res_valid is 2^N+1 cycles. For N=0 it is 2 cycles from the cfg handshake.
- Subset evaluation is a single-cycle combinational XOR/popcount tree feeding registered best state. No pipelining.

Optional Feature:
- Macro: DAY10_GRAY_ENUM_EN.
- Defined: subsets are visited in Gray-code order, g(i)=i^(i>>1), i=0..2^N-1.
  - acc is a register updated each cycle by XOR with the single mask whose bit flips.
  - pc is a register incremented or decremented by 1.
  - This removes the N-input XOR tree. Cycle count is unchanged.
  - The tie-break is first-encountered in Gray order.
- Undefined: binary counter order with combinational XOR/popcount, as described above.
- In both modes min_button_presses and res_found are identical.

Test Plan:
- Target 0x6, N=6, masks 0x8,0xA,0x4,0xC,0x5,0x3 -> res_found=1, min=2, buttons_to_press=0x00A in both modes; res_valid 65 cycles after the last btn handshake.
- Target 0x08, N=5, masks 0x1D,0x0C,0x11,0x07,0x1E -> res_found=1, min=3; the XOR of the reported masks equals 0x08 and the popcount of buttons_to_press is 3.
- Target 0x3, N=2, masks 0x1,0x1 -> res_found=0, min=all-ones, buttons_to_press=0.
- Target 0x0, N=0 -> res_valid after 2 cycles, found=1, min=0. Also N=20 with MAX=13 -> exactly 13 btn handshakes accepted.
- Hold res_ready=0 for 10 cycles in DONE -> res_valid and all fields stable, cfg_ready=0. Then res_ready=1 -> IDLE next cycle with cfg_ready=1.
- Assert rst_n low mid-LOAD and again mid-SEARCH -> all outputs 0 immediately; a fresh job afterwards produces the correct result unaffected by the prior masks.
